// File: rtl/game_pkg.sv
// Shared constants for the game step controller and the speed divider:
// level range, level width and FSM state encoding.
package game_pkg;

  localparam int LVL_W             = 4;
  localparam int MIN_LEVEL         = 1;
  localparam int MAX_LEVEL_DEFAULT = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/game_step_controller_tick_edge_detect.sv
// Two-flop history on a slow toggle input; rise is high for the one clk
// cycle after the synchronised input is first seen high.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic d1_q, d1_d;
  logic d2_q, d2_d;

  always_comb begin
    d1_d = din;
    d2_d = d1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign rise = d1_q & ~d2_q;

endmodule

// File: rtl/game_step_controller.sv
// Turns divider toggles into clk-domain step/move events, owns the level register.
// Build option: define OVERRUN_COUNT_EN to enable the dropped-step counter.
module game_step_controller
  import game_pkg::*;
#(
  parameter int EVTS_PER_LEVEL = 10,
  parameter int MAX_LEVEL      = MAX_LEVEL_DEFAULT,
  parameter int OVR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clock,
  input  logic             div_move,
  input  logic             pause,
  input  logic             score_evt,
  input  logic             step_ack,
  output logic             step_req,
  output logic             move_pulse,
  output logic [LVL_W-1:0] curr_level,
  output logic             level_up,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int               CNT_W    = $clog2(EVTS_PER_LEVEL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVTS_PER_LEVEL - 1);
  localparam logic [LVL_W-1:0] LVL_MIN  = LVL_W'(MIN_LEVEL);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(MAX_LEVEL);

  logic rise_clock, rise_move;

  tick_edge_detect u_clock_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (div_clock),
    .rise (rise_clock)
  );

  tick_edge_detect u_move_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (div_move),
    .rise (rise_move)
  );

  state_e             state_q, state_d;
  logic               pend_saved_q, pend_saved_d;
  logic               step_req_q, step_req_d;
  logic               move_pulse_q, move_pulse_d;
  logic [CNT_W-1:0]   score_cnt_q, score_cnt_d;
  logic [LVL_W-1:0]   curr_level_q, curr_level_d;
  logic               level_up_q, level_up_d;

  // Pause outranks ack and rise; a step pending at pause is restored afterwards.
  always_comb begin
    state_d      = state_q;
    pend_saved_d = pend_saved_q;
    case (state_q)
      ST_IDLE: begin
        if (pause) begin
          state_d      = ST_PAUSED;
          pend_saved_d = 1'b0;
        end else if (rise_clock) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (pause) begin
          state_d      = ST_PAUSED;
          pend_saved_d = 1'b1;
        end else if (step_ack && !rise_clock) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAUSED: begin
        if (!pause) state_d = pend_saved_q ? ST_PEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    step_req_d   = (state_d == ST_PEND);
    move_pulse_d = rise_move & ~pause;
  end

  always_comb begin
    score_cnt_d  = score_cnt_q;
    curr_level_d = curr_level_q;
    level_up_d   = 1'b0;
    if (score_evt) begin
      if (score_cnt_q == CNT_LAST) begin
        score_cnt_d = '0;
        if (curr_level_q < LVL_MAX) begin
          curr_level_d = curr_level_q + 1'b1;
          level_up_d   = 1'b1;
        end
      end else begin
        score_cnt_d = score_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_saved_q <= 1'b0;
      step_req_q   <= 1'b0;
      move_pulse_q <= 1'b0;
      score_cnt_q  <= '0;
      curr_level_q <= LVL_MIN;
      level_up_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_saved_q <= pend_saved_d;
      step_req_q   <= step_req_d;
      move_pulse_q <= move_pulse_d;
      score_cnt_q  <= score_cnt_d;
      curr_level_q <= curr_level_d;
      level_up_q   <= level_up_d;
    end
  end

`ifdef OVERRUN_COUNT_EN
  logic             ovr_inc;
  logic [OVR_W-1:0] ovr_q, ovr_d;

  // A new tick while a step is still pending and unacked is a dropped step.
  assign ovr_inc = (state_q == ST_PEND) && !pause && rise_clock && !step_ack;

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_inc && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= '0;
    else     ovr_q <= ovr_d;
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

  assign step_req   = step_req_q;
  assign move_pulse = move_pulse_q;
  assign curr_level = curr_level_q;
  assign level_up   = level_up_q;

endmodule

// File: tb/tb_game_step_controller.sv
// Directed bench for game_step_controller; overrun expectations follow OVERRUN_COUNT_EN.
module tb_game_step_controller;

  import game_pkg::*;

`ifdef OVERRUN_COUNT_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, div_clock, div_move, pause, score_evt, step_ack;
  logic       step_req, move_pulse, level_up;
  logic [3:0] curr_level;
  logic [7:0] overrun_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  game_step_controller dut (
    .clk         (clk),
    .rst         (rst),
    .div_clock   (div_clock),
    .div_move    (div_move),
    .pause       (pause),
    .score_evt   (score_evt),
    .step_ack    (step_ack),
    .step_req    (step_req),
    .move_pulse  (move_pulse),
    .curr_level  (curr_level),
    .level_up    (level_up),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_clock();
    div_clock = 1'b1;
    tick();
    tick();
    div_clock = 1'b0;
    tick();
    tick();
  endtask

  task automatic score_pulses(input int n, output int ups);
    ups = 0;
    for (int i = 0; i < n; i++) begin
      score_evt = 1'b1;
      tick();
      ups += int'(level_up);
      score_evt = 1'b0;
      tick();
      ups += int'(level_up);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; div_clock = 1'b0; div_move = 1'b0; pause = 1'b0;
    score_evt = 1'b0; step_ack = 1'b0;
    do_reset();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL reset_step_req: got %b want 0", step_req); end
    n_cmp++; if (move_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_move_pulse: got %b want 0", move_pulse); end
    n_cmp++; if (level_up !== 1'b0) begin n_fail++; $display("FAIL reset_level_up: got %b want 0", level_up); end
    n_cmp++; if (curr_level !== 4'd1) begin n_fail++; $display("FAIL reset_level: got %0d want 1", curr_level); end
    n_cmp++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_overrun: got %0d want 0", overrun_cnt); end
  endtask

  task automatic test_step();
    div_clock = 1'b1;
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL step_early: got %b want 0", step_req); end
    tick();
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL step_rise: got %b want 1", step_req); end
    div_clock = 1'b0;
    tick();
    tick();
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL step_held: got %b want 1", step_req); end
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL step_acked: got %b want 0", step_req); end
    n_cmp++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL step_overrun: got %0d want 0", overrun_cnt); end
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL step_idle: got %b want 0", step_req); end
  endtask

  task automatic test_move();
    div_move = 1'b1;
    tick();
    n_cmp++; if (move_pulse !== 1'b0) begin n_fail++; $display("FAIL move_early: got %b want 0", move_pulse); end
    tick();
    n_cmp++; if (move_pulse !== 1'b1) begin n_fail++; $display("FAIL move_pulse: got %b want 1", move_pulse); end
    tick();
    n_cmp++; if (move_pulse !== 1'b0) begin n_fail++; $display("FAIL move_one_cycle: got %b want 0", move_pulse); end
    div_move = 1'b0;
    tick();
    tick();
    n_cmp++; if (move_pulse !== 1'b0) begin n_fail++; $display("FAIL move_fall: got %b want 0", move_pulse); end
  endtask

  task automatic test_overrun();
    do_reset();
    pulse_clock();
    pulse_clock();
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL ovr_step_req: got %b want 1", step_req); end
    n_cmp++; if (overrun_cnt !== (OVR_ON ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL ovr_one: got %0d want %0d", overrun_cnt, OVR_ON ? 1 : 0); end
    for (int i = 0; i < 299; i++) pulse_clock();
    n_cmp++; if (overrun_cnt !== (OVR_ON ? 8'd255 : 8'd0)) begin
      n_fail++; $display("FAIL ovr_saturate: got %0d want %0d", overrun_cnt, OVR_ON ? 255 : 0); end
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL ovr_ack: got %b want 0", step_req); end
  endtask

  task automatic test_pause();
    logic sr_seen, mp_seen;
    do_reset();
    pulse_clock();
    pulse_clock();
    pause = 1'b1;
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL pause_drop: got %b want 0", step_req); end
    sr_seen = 1'b0;
    mp_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      div_clock = 1'b1; div_move = 1'b1; step_ack = (i == 1);
      tick(); sr_seen |= step_req; mp_seen |= move_pulse;
      tick(); sr_seen |= step_req; mp_seen |= move_pulse;
      div_clock = 1'b0; div_move = 1'b0; step_ack = 1'b0;
      tick(); sr_seen |= step_req; mp_seen |= move_pulse;
      tick(); sr_seen |= step_req; mp_seen |= move_pulse;
    end
    n_cmp++; if (sr_seen !== 1'b0) begin n_fail++; $display("FAIL pause_step_req: got %b want 0", sr_seen); end
    n_cmp++; if (mp_seen !== 1'b0) begin n_fail++; $display("FAIL pause_move: got %b want 0", mp_seen); end
    pause = 1'b0;
    tick();
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL pause_restore: got %b want 1", step_req); end
    n_cmp++; if (overrun_cnt !== (OVR_ON ? 8'd1 : 8'd0)) begin
      n_fail++; $display("FAIL pause_overrun: got %0d want %0d", overrun_cnt, OVR_ON ? 1 : 0); end
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    pause = 1'b1;
    tick();
    pause = 1'b0;
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL pause_idle_return: got %b want 0", step_req); end
  endtask

  task automatic test_level();
    int ups;
    do_reset();
    score_pulses(9, ups);
    n_cmp++; if (curr_level !== 4'd1) begin n_fail++; $display("FAIL lvl_nine_evts: got %0d want 1", curr_level); end
    score_evt = 1'b1;
    tick();
    score_evt = 1'b0;
    n_cmp++; if (level_up !== 1'b1) begin n_fail++; $display("FAIL lvl_up_pulse: got %b want 1", level_up); end
    n_cmp++; if (curr_level !== 4'd2) begin n_fail++; $display("FAIL lvl_two: got %0d want 2", curr_level); end
    tick();
    n_cmp++; if (level_up !== 1'b0) begin n_fail++; $display("FAIL lvl_up_width: got %b want 0", level_up); end
    pause = 1'b1;
    score_pulses(90, ups);
    pause = 1'b0;
    n_cmp++; if (curr_level !== 4'd9) begin n_fail++; $display("FAIL lvl_max: got %0d want 9", curr_level); end
    n_cmp++; if (ups !== 7) begin n_fail++; $display("FAIL lvl_up_count: got %0d want 7", ups); end
    score_pulses(10, ups);
    n_cmp++; if (curr_level !== 4'd9) begin n_fail++; $display("FAIL lvl_hold: got %0d want 9", curr_level); end
    n_cmp++; if (ups !== 0) begin n_fail++; $display("FAIL lvl_no_up_at_max: got %0d want 0", ups); end
  endtask

  task automatic test_back_to_back();
    int ups;
    do_reset();
    pulse_clock();
    div_clock = 1'b1;
    tick();
    step_ack = 1'b1;
    tick();
    step_ack = 1'b0;
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL b2b_step_req: got %b want 1", step_req); end
    n_cmp++; if (overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 0", overrun_cnt); end
    div_clock = 1'b0;
    tick();
    tick();
    n_cmp++; if (step_req !== 1'b1) begin n_fail++; $display("FAIL b2b_still_pend: got %b want 1", step_req); end
    score_pulses(10, ups);
    n_cmp++; if (curr_level !== 4'd2) begin n_fail++; $display("FAIL b2b_level: got %0d want 2", curr_level); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pend: got %b want 0", step_req); end
    n_cmp++; if (curr_level !== 4'd1) begin n_fail++; $display("FAIL rst_level: got %0d want 1", curr_level); end
    tick();
    tick();
    n_cmp++; if (step_req !== 1'b0) begin n_fail++; $display("FAIL rst_no_ack: got %b want 0", step_req); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_move();
    test_overrun();
    test_pause();
    test_level();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
